// File: rtl/sps_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sps_pkg
// Description : Frame constants and receiver state type shared by the serial
//               link transmitter (PISO) and receiver (SIPO).
// Revision    : 1.0 - initial release
// ============================================================================
package sps_pkg;

    localparam int   BIT_TICKS   = 16;
    localparam int   DATA_BITS   = 8;
    localparam int   PARITY_EVEN = 1;
    localparam logic START_BIT   = 1'b0;
    localparam logic STOP_BIT    = 1'b1;
    localparam int   FRAME_BITS  = 11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage : sps_pkg
`default_nettype wire

// File: rtl/sipo_receiver_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer; both stages reset to RESET_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/sipo_receiver.sv
`default_nettype none
// ============================================================================
// Module      : sipo_receiver
// Description : Serial frame receiver (start, data LSB-first, parity, stop)
//               with mid-bit sampling, parallel output strobe and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_receiver #(
    parameter int BIT_TICKS   = sps_pkg::BIT_TICKS,
    parameter int DATA_BITS   = sps_pkg::DATA_BITS,
    parameter int PARITY_EVEN = sps_pkg::PARITY_EVEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 serialIn,
    output logic [DATA_BITS-1:0] parallelOut,
    output logic                 charReceived,
    output logic                 parityError,
    output logic                 frameError,
    output logic                 busy
);

    import sps_pkg::*;

    localparam int   c_tick_w  = $clog2(BIT_TICKS);
    localparam int   c_bit_w   = $clog2(DATA_BITS + 1);
    localparam logic c_par_odd = (PARITY_EVEN == 0);

    localparam logic [c_tick_w-1:0] c_tick_half = c_tick_w'(BIT_TICKS / 2 - 1);
    localparam logic [c_tick_w-1:0] c_tick_full = c_tick_w'(BIT_TICKS - 1);
    localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(DATA_BITS - 1);

    rx_state_t                state_q,  state_d;
    logic [c_tick_w-1:0]      tick_q,   tick_d;
    logic [c_bit_w-1:0]       bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0]     shift_q,  shift_d;
    logic                     par_q,    par_d;
    logic                     stop_q,   stop_d;
    logic                     done_q,   done_d;
    logic [DATA_BITS-1:0]     dout_q,   dout_d;
    logic                     strobe_q, strobe_d;
    logic                     perr_q,   perr_d;
    logic                     ferr_q,   ferr_d;

    logic w_rxs;
    logic w_half_hit;
    logic w_full_hit;
    logic w_par_err;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (serialIn),
        .q_o   (w_rxs)
    );

    assign w_half_hit = (tick_q == c_tick_half);
    assign w_full_hit = (tick_q == c_tick_full);
    assign w_par_err  = ((^shift_q) ^ par_q) != c_par_odd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            stop_q   <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= '0;
            strobe_q <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            stop_q   <= stop_d;
            done_q   <= done_d;
            dout_q   <= dout_d;
            strobe_q <= strobe_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        stop_d   = stop_q;
        done_d   = 1'b0;
        dout_d   = dout_q;
        strobe_d = 1'b0;
        perr_d   = perr_q;
        ferr_d   = ferr_q;

        unique case (state_q)
            IDLE: begin
                if (enable && (w_rxs == START_BIT)) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end

            START: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (w_half_hit) begin
                    // A start bit that is gone by mid-bit was a glitch
                    if (w_rxs == START_BIT) begin
                        state_d  = DATA;
                        tick_d   = '0;
                        bitcnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + c_tick_w'(1);
                end
            end

            DATA: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (w_full_hit) begin
                    tick_d   = '0;
                    shift_d  = {w_rxs, shift_q[DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + c_bit_w'(1);
                    if (bitcnt_q == c_last_bit) begin
                        state_d = PARITY;
                    end
                end else begin
                    tick_d = tick_q + c_tick_w'(1);
                end
            end

            PARITY: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (w_full_hit) begin
                    tick_d  = '0;
                    par_d   = w_rxs;
                    state_d = STOP;
                end else begin
                    tick_d = tick_q + c_tick_w'(1);
                end
            end

            STOP: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (done_q) begin
                    // Stop bit was sampled last cycle; publish the frame now
                    dout_d   = shift_q;
                    strobe_d = 1'b1;
                    ferr_d   = (stop_q != STOP_BIT);
                    perr_d   = w_par_err;
                    state_d  = (stop_q == STOP_BIT) ? IDLE : WAIT_HIGH;
                end else if (w_full_hit) begin
                    stop_d = w_rxs;
                    done_d = 1'b1;
                end else begin
                    tick_d = tick_q + c_tick_w'(1);
                end
            end

            WAIT_HIGH: begin
                if (w_rxs) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign parallelOut  = dout_q;
    assign charReceived = strobe_q;
    assign parityError  = perr_q;
    assign frameError   = ferr_q;
    assign busy         = (state_q != IDLE);

endmodule : sipo_receiver
`default_nettype wire

// File: tb/tb_sipo_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_receiver
// Description : Self-checking bench: frame table plus corner-case sequences,
//               strobes compared against a scoreboard of expected frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_receiver;

    localparam int BT  = 16;
    // Start-bit drive edge to strobe: 2 sync stages, 1 detect, then D+169
    localparam int LAT = 172;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       enable   = 1'b1;
    logic       serialIn = 1'b1;
    logic [7:0] parallelOut;
    logic       charReceived;
    logic       parityError;
    logic       frameError;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         at;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       flip;
        logic       exp_pe;
    } vec_t;

    exp_t exp_q[$];
    int   strobe_log[$];
    exp_t mon_e;
    vec_t vecs[6];

    sipo_receiver #(
        .BIT_TICKS   (BT),
        .DATA_BITS   (8),
        .PARITY_EVEN (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .serialIn     (serialIn),
        .parallelOut  (parallelOut),
        .charReceived (charReceived),
        .parityError  (parityError),
        .frameError   (frameError),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (charReceived === 1'b1) begin
            strobe_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'(cyc), 32'hFFFFFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("parallelOut", 32'(parallelOut), 32'(mon_e.d));
                chk("parityError", 32'(parityError), 32'(mon_e.pe));
                chk("frameError",  32'(frameError),  32'(mon_e.fe));
                chk("strobe_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    // Caller must be at posedge+#1; returns at posedge+#1 after a full frame,
    // or right on the posedge when cut short by max_cycles.
    task automatic send_frame(input logic [7:0] data, input logic flip, input logic stop_b,
                              input int max_cycles, input logic expect_strobe,
                              input logic exp_pe);
        logic [10:0] wire_bits;
        int          n;
        exp_t        e;
        wire_bits = {stop_b, (^data) ^ flip, data, 1'b0};
        if (expect_strobe) begin
            e.d  = data;
            e.pe = exp_pe;
            e.fe = ~stop_b;
            e.at = cyc + LAT;
            exp_q.push_back(e);
        end
        n = 0;
        for (int i = 0; i < 11; i++) begin
            serialIn = wire_bits[i];
            for (int j = 0; j < BT; j++) begin
                @(posedge clk);
                n++;
                if (n >= max_cycles) return;
            end
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d frames pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0] = '{8'hAA, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1};
        vecs[2] = '{8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b1};

        // Reset state
        idle(3);
        chk("reset_parallelOut", 32'(parallelOut), 32'h0);
        chk("reset_flags", {29'd0, charReceived, parityError, frameError}, 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        idle(5);

        // Table-driven frames
        foreach (vecs[k]) begin
            send_frame(vecs[k].data, vecs[k].flip, 1'b1, 1000, 1'b1, vecs[k].exp_pe);
            idle(10);
            chk("idle_after_frame_busy", 32'(busy), 32'h0);
        end

        // Short low pulse: glitch rejected in START
        n = cyc;
        serialIn = 1'b0;
        idle(3);
        serialIn = 1'b1;
        chk("glitch_busy_in_start", 32'(busy), 32'h1);
        repeat (12 - (cyc - n)) @(posedge clk);
        #1;
        chk("glitch_busy_low_by_D9", 32'(busy), 32'h0);
        idle(20);

        // Stop bit low, line held low: WAIT_HIGH until release
        send_frame(8'h55, 1'b0, 1'b0, 1000, 1'b1, 1'b0);
        idle(40);
        chk("wait_high_busy", 32'(busy), 32'h1);
        serialIn = 1'b1;
        idle(5);
        chk("wait_high_released", 32'(busy), 32'h0);
        chk("frameError_held", 32'(frameError), 32'h1);

        // Enable dropped mid-frame: abort, outputs unchanged
        send_frame(8'h12, 1'b0, 1'b1, 50, 1'b0, 1'b0);
        #1;
        enable   = 1'b0;
        serialIn = 1'b1;
        idle(2);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_parallelOut_held", 32'(parallelOut), 32'h55);
        idle(5);
        enable = 1'b1;
        idle(10);

        // Reset mid-frame, then a clean frame
        send_frame(8'hAA, 1'b0, 1'b1, 63, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        #1;
        chk("midreset_parallelOut", 32'(parallelOut), 32'h0);
        chk("midreset_flags", {29'd0, charReceived, parityError, frameError}, 32'h0);
        chk("midreset_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        serialIn = 1'b1;
        rst      = 1'b1;
        idle(10);
        send_frame(8'h0F, 1'b0, 1'b1, 1000, 1'b1, 1'b0);
        idle(10);

        // Back-to-back frames, no idle gap
        n = strobe_log.size();
        send_frame(8'hAA, 1'b0, 1'b1, 1000, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1000, 1'b1, 1'b0);
        idle(10);
        if (strobe_log.size() >= n + 2)
            chk("b2b_spacing", 32'(strobe_log[n+1] - strobe_log[n]), 32'd176);
        else
            chk("b2b_strobe_count", 32'(strobe_log.size() - n), 32'd2);

        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sipo_receiver
`default_nettype wire
